// File: rtl/fir_error_monitor_if.sv
// Sample-pair stream and result bus between the FIR output side and the error monitor.
// The master drives the samples and start; the slave (the monitor) returns status and results.
interface fir_error_monitor_if #(
  parameter int W     = 16,
  parameter int ACC_W = 32
);
  logic             start;
  logic             valid;
  logic [W-1:0]     approx_in;
  logic [W-1:0]     exact_in;
  logic             busy;
  logic             done;
  logic [15:0]      err_count;
  logic [ACC_W-1:0] err_sum;
  logic [W-1:0]     err_max;
  logic [15:0]      sample_cnt;

  modport master (
    output start, valid, approx_in, exact_in,
    input  busy, done, err_count, err_sum, err_max, sample_cnt
  );

  modport slave (
    input  start, valid, approx_in, exact_in,
    output busy, done, err_count, err_sum, err_max, sample_cnt
  );
endinterface

// File: rtl/fir_error_monitor.sv
// Compares approximate and exact FIR outputs over a fixed window of accepted pairs and
// reports the mismatch count, saturating sum of absolute errors and maximum absolute error.
module fir_error_monitor #(
  parameter int N_SAMPLES = 256,
  parameter int W         = 16,
  parameter int ACC_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  fir_error_monitor_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

  logic [1:0]       state;
  logic [15:0]      sample_cnt;
  logic             s1_valid;
  logic             s1_neq;
  logic [W-1:0]     s1_diff;
  logic [15:0]      err_count;
  logic [ACC_W-1:0] err_sum;
  logic [W-1:0]     err_max;
  logic             done_q;

  logic             launch;
  logic             accept;
  logic             last_accept;
  logic [W-1:0]     diff;
  logic [ACC_W:0]   sum_wide;

  assign launch      = bus.start && ((state == IDLE) || (state == DONE));
  assign accept      = (state == RUN) && bus.valid;
  assign last_accept = accept && (sample_cnt == LAST_IDX);

  // The larger operand is always the minuend, so the W-bit difference is exact.
  always_comb begin
    if (bus.approx_in >= bus.exact_in) diff = bus.approx_in - bus.exact_in;
    else                               diff = bus.exact_in - bus.approx_in;
  end

  assign sum_wide = {1'b0, err_sum} + {{(ACC_W + 1 - W){1'b0}}, s1_diff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == DRAIN);
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state      <= RUN;
            sample_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) sample_cnt <= sample_cnt + 16'd1;
          if (last_accept) state <= DRAIN;
        end
        default: state <= DONE;
      endcase
    end
  end

  // Stage 1: register the per-pair error; the flag is dropped on launch so no stale pair survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_neq   <= 1'b0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= accept && !launch;
      if (accept) begin
        s1_neq  <= (bus.approx_in != bus.exact_in);
        s1_diff <= diff;
      end
    end
  end

  // Stage 2: saturating accumulation of the window statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_sum   <= '0;
      err_max   <= '0;
    end else if (launch) begin
      err_count <= '0;
      err_sum   <= '0;
      err_max   <= '0;
    end else if (s1_valid) begin
      err_sum <= sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
      if (s1_neq && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      if (s1_diff > err_max) err_max <= s1_diff;
    end
  end

  assign bus.busy       = (state == RUN) || (state == DRAIN);
  assign bus.done       = done_q;
  assign bus.sample_cnt = sample_cnt;
  assign bus.err_count  = err_count;
  assign bus.err_sum    = err_sum;
  assign bus.err_max    = err_max;

endmodule
